// File: rtl/and_or_vector_sweeper.sv
// rtl/and_or_vector_sweeper.sv - exhaustive vector sweeper with truth-table response capture
//
// Drives every vector 0 .. 2^WIDTH-1 onto vec_out_o, holding each for
// HOLD_CYCLES cycles. On the last hold cycle of each vector it samples the
// combinational block's 1-bit response into resp_map_o[vector].
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   start_i      sweep request, honoured only in IDLE
//   vec_out_o    vector driven to the block under test
//   vec_valid_o  high while vec_out_o carries a sweep vector
//   resp_i       response of the block under test to vec_out_o
//   busy_o       high for the whole sweep
//   done_o       one-cycle pulse after the final vector
//   resp_map_o   bit k = response captured for vector k
module and_or_vector_sweeper #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    output logic [WIDTH-1:0]        vec_out_o,
    output logic                    vec_valid_o,
    input  logic                    resp_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [(1<<WIDTH)-1:0]   resp_map_o
);

    localparam int MAP_W = 1 << WIDTH;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] VEC_LAST = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAP_W-1:0]   map_q, map_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            map_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            map_q   <= map_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        map_d   = map_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DRIVE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    map_d   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    // Sample on the edge that ends the vector's final hold cycle.
                    map_d[vec_q] = resp_i;
                    cnt_d        = '0;
                    if (vec_q != VEC_LAST) begin
                        vec_d = vec_q + WIDTH'(1);
                    end else begin
                        vec_d   = '0;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                vec_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe and never see start_i/resp_i directly.
        busy_d = (state_d == S_DRIVE);
        done_d = (state_d == S_DONE);
    end

    assign vec_out_o   = vec_q;
    assign vec_valid_o = busy_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign resp_map_o  = map_q;

endmodule
